// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// default table size and the counter value given to newly allocated entries.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int   DEFAULT_ENTRIES = 64;
  localparam ctr_e ALLOC_CTR       = WT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
  import bpu_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next_ctr
);

  // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
  always_comb begin
    next_ctr = ctr;
    case (ctr)
      SNT:     next_ctr = taken ? WNT : SNT;
      WNT:     next_ctr = taken ? WT  : SNT;
      WT:      next_ctr = taken ? ST  : WNT;
      ST:      next_ctr = taken ? ST  : WT;
      default: next_ctr = WNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF-stage lookup, EX-stage
// mispredict detection/redirect, table training and branch statistics.
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_IF,
  output logic        predTaken_IF,
  output logic [31:0] predTarget_IF,
  output logic [31:0] nextPC,
  input  logic        branch_EX,
  input  logic [31:0] pc_EX,
  input  logic        taken_EX,
  input  logic [31:0] target_EX,
  input  logic        predTaken_EX,
  input  logic [31:0] predTarget_EX,
  output logic        flush,
  output logic [31:0] redirectPC,
  output logic [31:0] branchCount,
  output logic [31:0] mispredCount
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = 30 - INDEX_W;

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [31:0]       target_r [ENTRIES];
  logic [1:0]        ctr_r    [ENTRIES];
  logic [31:0]       branch_count_r;
  logic [31:0]       mispred_count_r;

  logic [INDEX_W-1:0] if_idx_s;
  logic [TAG_W-1:0]   if_tag_s;
  logic               if_hit_s;
  logic [INDEX_W-1:0] ex_idx_s;
  logic [TAG_W-1:0]   ex_tag_s;
  logic               ex_hit_s;
  logic               branch_v_s;
  logic               mispredict_s;
  logic [1:0]         ex_next_ctr_s;

  assign if_idx_s = pc_IF[INDEX_W+1:2];
  assign if_tag_s = pc_IF[31:INDEX_W+2];
  assign ex_idx_s = pc_EX[INDEX_W+1:2];
  assign ex_tag_s = pc_EX[31:INDEX_W+2];

  // Branch resolution is ignored entirely while reset is held.
  assign branch_v_s = branch_EX & ~reset;
  assign if_hit_s   = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
  assign ex_hit_s   = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_r[ex_idx_s]),
    .taken    (taken_EX),
    .next_ctr (ex_next_ctr_s)
  );

  // IF lookup and EX mispredict/redirect; redirect overrides the prediction.
  always_comb begin
    predTaken_IF  = 1'b0;
    predTarget_IF = pc_IF + 32'd4;
    mispredict_s  = 1'b0;
    flush         = 1'b0;
    redirectPC    = 32'd0;
    if (!reset && if_hit_s && ctr_r[if_idx_s][1]) begin
      predTaken_IF  = 1'b1;
      predTarget_IF = target_r[if_idx_s];
    end else begin
      predTaken_IF  = 1'b0;
    end
    if (branch_v_s) begin
      mispredict_s = (taken_EX != predTaken_EX) ||
                     (taken_EX && (target_EX != predTarget_EX));
    end else begin
      mispredict_s = 1'b0;
    end
    if (mispredict_s) begin
      flush      = 1'b1;
      redirectPC = taken_EX ? target_EX : (pc_EX + 32'd4);
    end else begin
      flush      = 1'b0;
    end
    nextPC = flush ? redirectPC : predTarget_IF;
  end

  // Table training: update on hit, allocate on taken miss, ignore NT miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= WNT;
      end
    end else if (branch_EX) begin
      if (ex_hit_s) begin
        ctr_r[ex_idx_s] <= ex_next_ctr_s;
        if (taken_EX) begin
          target_r[ex_idx_s] <= target_EX;
        end
      end else if (taken_EX) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= target_EX;
        ctr_r[ex_idx_s]    <= ALLOC_CTR;
      end
    end
  end

  // Saturating branch and mispredict statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_r  <= 32'd0;
      mispred_count_r <= 32'd0;
    end else begin
      if (branch_EX && (branch_count_r != 32'hFFFF_FFFF)) begin
        branch_count_r <= branch_count_r + 32'd1;
      end
      if (mispredict_s && (mispred_count_r != 32'hFFFF_FFFF)) begin
        mispred_count_r <= mispred_count_r + 32'd1;
      end
    end
  end

  assign branchCount  = branch_count_r;
  assign mispredCount = mispred_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: each step pushes its expected
// outputs, which are popped and compared at the following falling edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_IF;
  logic        predTaken_IF;
  logic [31:0] predTarget_IF;
  logic [31:0] nextPC;
  logic        branch_EX;
  logic [31:0] pc_EX;
  logic        taken_EX;
  logic [31:0] target_EX;
  logic        predTaken_EX;
  logic [31:0] predTarget_EX;
  logic        flush;
  logic [31:0] redirectPC;
  logic [31:0] branchCount;
  logic [31:0] mispredCount;

  typedef struct {
    string       tag;
    logic        pt;
    logic [31:0] ptgt;
    logic [31:0] nxt;
    logic        fl;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks_r = 0;
  int          errors_r = 0;
  logic [31:0] model_bc = 32'd0;
  logic [31:0] model_mc = 32'd0;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_IF         (pc_IF),
    .predTaken_IF  (predTaken_IF),
    .predTarget_IF (predTarget_IF),
    .nextPC        (nextPC),
    .branch_EX     (branch_EX),
    .pc_EX         (pc_EX),
    .taken_EX      (taken_EX),
    .target_EX     (target_EX),
    .predTaken_EX  (predTaken_EX),
    .predTarget_EX (predTarget_EX),
    .flush         (flush),
    .redirectPC    (redirectPC),
    .branchCount   (branchCount),
    .mispredCount  (mispredCount)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of IF/EX inputs, push expectations, compare at negedge.
  task automatic step(input string tag, input logic [31:0] pcif,
                      input logic br, input logic [31:0] pcex, input logic tk,
                      input logic [31:0] tgt, input logic pt_ex, input logic [31:0] ptgt_ex,
                      input logic e_pt, input logic [31:0] e_ptgt,
                      input logic e_fl, input logic [31:0] e_rd);
    exp_t e;
    exp_t got;
    pc_IF = pcif; branch_EX = br; pc_EX = pcex; taken_EX = tk;
    target_EX = tgt; predTaken_EX = pt_ex; predTarget_EX = ptgt_ex;
    e.tag = tag; e.pt = e_pt; e.ptgt = e_ptgt; e.fl = e_fl; e.rd = e_rd;
    e.nxt = e_fl ? e_rd : e_ptgt;
    e.bc = model_bc; e.mc = model_mc;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    check_val({got.tag, ".predTaken"},  {31'd0, predTaken_IF}, {31'd0, got.pt});
    check_val({got.tag, ".predTarget"}, predTarget_IF, got.ptgt);
    check_val({got.tag, ".nextPC"},     nextPC, got.nxt);
    check_val({got.tag, ".flush"},      {31'd0, flush}, {31'd0, got.fl});
    check_val({got.tag, ".redirectPC"}, redirectPC, got.rd);
    check_val({got.tag, ".branchCount"},  branchCount, got.bc);
    check_val({got.tag, ".mispredCount"}, mispredCount, got.mc);
    if (br && !reset) model_bc = model_bc + 32'd1;
    if (e_fl) model_mc = model_mc + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // Reset state, with a junk branch that must be ignored.
    step("rst", 32'h40, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104,
         1'b0, 32'h44, 1'b0, 32'h0);
    reset = 1'b0;
    step("cold", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b0, 32'h44, 1'b0, 32'h0);
    // First taken branch; same-cycle lookup still misses.
    step("first_tk", 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104,
         1'b0, 32'h104, 1'b1, 32'h200);
    step("alloc_hit", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b1, 32'h200, 1'b0, 32'h0);
    // Train down 10 -> 01 -> 00.
    step("nt1", 32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200,
         1'b1, 32'h200, 1'b1, 32'h104);
    step("nt2", 32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104,
         1'b0, 32'h104, 1'b0, 32'h0);
    step("after_nt", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b0, 32'h104, 1'b0, 32'h0);
    // Saturation: 00 -> 01 -> 10 -> 11 -> 11, then NT -> 10.
    step("sat1", 32'h40, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104,
         1'b0, 32'h44, 1'b1, 32'h200);
    step("sat2", 32'h40, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104,
         1'b0, 32'h44, 1'b1, 32'h200);
    step("sat3", 32'h40, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200,
         1'b0, 32'h44, 1'b0, 32'h0);
    step("sat4", 32'h40, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200,
         1'b0, 32'h44, 1'b0, 32'h0);
    step("sat_nt", 32'h40, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200,
         1'b0, 32'h44, 1'b1, 32'h104);
    step("sat_chk", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b1, 32'h200, 1'b0, 32'h0);
    // Idle EX with junk inputs: no flush, no state change.
    step("idle_ex", 32'h100, 1'b0, 32'h100, 1'b0, 32'h999, 1'b1, 32'h200,
         1'b1, 32'h200, 1'b0, 32'h0);
    // Aliasing at index 0.
    step("alias_miss", 32'h1100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b0, 32'h1104, 1'b0, 32'h0);
    step("alias_alloc", 32'h40, 1'b1, 32'h1100, 1'b1, 32'h500, 1'b0, 32'h1104,
         1'b0, 32'h44, 1'b1, 32'h500);
    step("alias_old", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b0, 32'h104, 1'b0, 32'h0);
    step("alias_new", 32'h1100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b1, 32'h500, 1'b0, 32'h0);
    // Re-allocate 0x100, then target change with same-cycle lookup.
    step("realloc", 32'h40, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104,
         1'b0, 32'h44, 1'b1, 32'h200);
    step("tgt_chg", 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200,
         1'b1, 32'h200, 1'b1, 32'h300);
    step("tgt_new", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b1, 32'h300, 1'b0, 32'h0);
    // Asynchronous reset mid-cycle clears table and statistics.
    #2;
    reset = 1'b1;
    model_bc = 32'd0;
    model_mc = 32'd0;
    step("mid_rst", 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h300,
         1'b0, 32'h104, 1'b0, 32'h0);
    reset = 1'b0;
    step("post_rst", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         1'b0, 32'h104, 1'b0, 32'h0);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage MIPS pipeline: the producing end of the branch-resolution path that the execute stage closes. In IF it looks up the fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and supplies the predicted next PC. In EX it takes the resolved outcome, raises flush/redirect on a misprediction and trains the table. It also keeps branch and mispredict statistics.

## Interface
- ENTRIES, 64: BTB entries; power of two ≥ 4; INDEX_W = log2(ENTRIES).
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears table and statistics.
- pc_IF  in  32  fetch PC; low 2 bits are ignored.
- predTaken_IF  out  1  prediction for pc_IF; the pipeline carries it down to EX.
- predTarget_IF  out  32  predicted next PC; the pipeline carries it down to EX.
- nextPC  out  32  PC to fetch next cycle (redirect overrides prediction).
- branch_EX  in  1  valid conditional branch in EX this cycle; asserted for exactly one cycle per branch.
- pc_EX  in  32  PC of the branch in EX.
- taken_EX  in  1  resolved direction from the EX comparator.
- target_EX  in  32  resolved branch target.
- predTaken_EX, predTarget_EX  in  1, 32  prediction carried with the branch.
- flush  out  1  mispredict; squash IF/ID and ID/EX.
- redirectPC  out  32  correct PC when flush=1, else 0.
- branchCount, mispredCount  out  32 each  saturating statistics.

## Operation
- Index = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2]. Entry fields: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational): hit = valid && tag match. predTaken_IF = hit && ctr[1]. predTarget_IF = predTaken_IF ? target : pc_IF+4.
- Mispredict (combinational, only when branch_EX=1): taken_EX != predTaken_EX, or taken_EX && target_EX != predTarget_EX. flush = mispredict. redirectPC = taken_EX ? target_EX : pc_EX+4.
- nextPC = flush ? redirectPC : predTarget_IF.
- Update on clock edge when branch_EX=1, at pc_EX's index:
  - Hit: ctr saturates, incrementing on taken and decrementing on not-taken (11 stays 11, 00 stays 00). If taken, target ← target_EX.
  - Miss and taken: allocate; valid=1, tag, target=target_EX, ctr=10 (weakly taken). The previous occupant is overwritten.
  - Miss and not-taken: no change.
- Statistics: branchCount increments on every branch_EX. mispredCount increments on every flush. Both hold at 0xFFFFFFFF.
- Counter encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

## Timing
- Lookup: 0-cycle latency. flush/redirectPC: 0-cycle latency from EX inputs.
- A table write becomes visible to lookup on the cycle after the edge. There is no write-to-read bypass: a same-cycle lookup of the index being written returns the old contents.
- Reset (asserted at any time, including mid-update) immediately clears all valid bits, sets every ctr to 01 and target to 0, and zeroes both counters.
- Values while reset is asserted:
  - predTaken_IF=0; predTarget_IF=nextPC=pc_IF+4.
  - flush=0; redirectPC=0, because branch_EX is ignored during reset.
- branch_EX=0: no state change and flush=0, regardless of the other EX inputs.

## Structure
- bpu_pkg holds:
  - counter encodings SNT/WNT/WT/ST;
  - default ENTRIES;
  - the allocation counter value (WT).
- The sub-module sat_counter2 computes a 2-bit saturating next state from (ctr, taken). It is instantiated once, for the EX update.
- The table is a register array so that the asynchronous reset clear is possible. It is not inferred RAM.

## Test plan
- Cold lookup: reset, then pc_IF=0x40 -> predTaken_IF=0, nextPC=0x44.
- First taken branch: branch_EX with pc_EX=0x100, taken_EX=1, target_EX=0x200, predTaken_EX=0 -> flush=1, redirectPC=0x200, mispredCount=1. Next cycle pc_IF=0x100 -> predTaken_IF=1, nextPC=0x200, ctr=10.
- Training down: two not-taken resolutions at 0x100 with the correct preds (1 then 0):
  - ctr goes 10→01→00;
  - first resolution flushes with redirectPC=0x104, second does not;
  - pc_IF=0x100 -> predTaken_IF=0.
- Saturation: four taken resolutions at 0x100 -> ctr=11; one not-taken -> ctr=10, prediction still taken.
- Aliasing: with 0x100 allocated, pc_IF=0x1100 (same index, other tag) -> miss, nextPC=0x1104. A taken branch at 0x1100 replaces the entry, after which 0x100 misses.
- Target change and write/read collision:
  - Correctly predicted taken at 0x100 but target_EX=0x300 vs predTarget_EX=0x200 -> flush=1, redirectPC=0x300.
  - Same-cycle pc_IF=0x100 -> nextPC=0x300 (redirect wins); predTarget_IF=0x200 (old entry); next cycle 0x300.
